// File: rtl/stream_mux_n.sv
// stream_mux_n
// Registered N-channel stream multiplexer with a valid/ready handshake on every
// channel. One input channel is granted per cycle, chosen either by an explicit
// select (manual mode) or by round-robin arbitration. The granted word is loaded
// into a single output register that the consumer drains with s_ready_in.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   a_in         packed channel data, channel i at [i*WIDTH +: WIDTH]
//   a_valid_in   per-channel valid
//   a_ready_out  per-channel ready (combinational, at most one bit set)
//   mode_in      0 = manual select via s_in, 1 = round-robin
//   s_in         manual channel select (values >= CHANNELS never grant)
//   s_out        registered output word
//   s_valid_out  output register holds a word
//   s_ready_in   consumer accepts the output word
//   s_chan_out   index of the channel that supplied s_out
module stream_mux_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] a_in,
  input  logic [CHANNELS-1:0]       a_valid_in,
  output logic [CHANNELS-1:0]       a_ready_out,
  input  logic                      mode_in,
  input  logic [SEL_W-1:0]          s_in,
  output logic [WIDTH-1:0]          s_out,
  output logic                      s_valid_out,
  input  logic                      s_ready_in,
  output logic [SEL_W-1:0]          s_chan_out
);

  // Reset value of the round-robin pointer: pointing at the last channel makes
  // channel 0 the first candidate after reset.
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0]    s_out_q, s_out_d;
  logic [SEL_W-1:0]    s_chan_q, s_chan_d;
  logic                s_valid_q, s_valid_d;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [WIDTH-1:0]    chan_data [CHANNELS];
  logic [CHANNELS-1:0] man_req;
  logic                man_hit;
  logic [SEL_W-1:0]    man_idx;
  logic                rr_hit;
  logic [SEL_W-1:0]    rr_idx;
  logic [SEL_W-1:0]    rr_cand;
  logic                grant_hit;
  logic [SEL_W-1:0]    grant_idx;
  logic [CHANNELS-1:0] grant_onehot;
  logic                can_load;
  logic                xfer;
  logic [WIDTH-1:0]    load_data;

  // Unpack channel data and decode the manual select against each channel.
  // Comparing s_in against every legal index means an out-of-range select
  // simply matches nothing.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan_data[gi] = a_in[gi*WIDTH +: WIDTH];
      assign man_req[gi]   = a_valid_in[gi] && (s_in == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    man_hit = |man_req;
    man_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (man_req[i]) man_idx = SEL_W'(i);
    end
  end

  // Round-robin search: candidates rr_ptr+1, rr_ptr+2, ... wrapping, with
  // rr_ptr itself visited last (k = CHANNELS). First valid candidate wins.
  always_comb begin
    rr_hit  = 1'b0;
    rr_idx  = '0;
    rr_cand = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      rr_cand = SEL_W'((int'(rr_ptr_q) + k) % CHANNELS);
      for (int i = 0; i < CHANNELS; i++) begin
        if (!rr_hit && (rr_cand == SEL_W'(i)) && a_valid_in[i]) begin
          rr_hit = 1'b1;
          rr_idx = rr_cand;
        end
      end
    end
  end

  assign grant_hit = mode_in ? rr_hit : man_hit;
  assign grant_idx = mode_in ? rr_idx : man_idx;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_grant
      assign grant_onehot[gi] = grant_hit && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  // The register may take a new word when empty or when its current word
  // retires in this same cycle (no bubble).
  assign can_load    = !s_valid_q || s_ready_in;
  assign a_ready_out = (rst_n && can_load) ? grant_onehot : '0;
  assign xfer        = rst_n && can_load && grant_hit;

  always_comb begin
    load_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_onehot[i]) load_data = chan_data[i];
    end
  end

  always_comb begin
    s_out_d   = s_out_q;
    s_chan_d  = s_chan_q;
    s_valid_d = s_valid_q;
    rr_ptr_d  = rr_ptr_q;
    // Retire first; a load in the same cycle overrides it below.
    if (s_valid_q && s_ready_in) s_valid_d = 1'b0;
    if (xfer) begin
      s_out_d   = load_data;
      s_chan_d  = grant_idx;
      s_valid_d = 1'b1;
      // Manual-mode transfers leave the arbitration history untouched.
      if (mode_in) rr_ptr_d = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_out_q   <= '0;
      s_chan_q  <= '0;
      s_valid_q <= 1'b0;
      rr_ptr_q  <= LAST_CH;
    end else begin
      s_out_q   <= s_out_d;
      s_chan_q  <= s_chan_d;
      s_valid_q <= s_valid_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign s_out       = s_out_q;
  assign s_chan_out  = s_chan_q;
  assign s_valid_out = s_valid_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Testbench for stream_mux_n (WIDTH=8, CHANNELS=4, SEL_W=3 so that an
// out-of-range select of 5 can be driven). A table of one-cycle vectors is
// applied; each vector checks a_ready_out before the edge and the output
// register after the edge. A short hand-written sequence follows.
module tb_stream_mux_n;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int SW = 3;

  logic             clk;
  logic             rst_n;
  logic [CH*W-1:0]  a_in;
  logic [CH-1:0]    a_valid_in;
  logic [CH-1:0]    a_ready_out;
  logic             mode_in;
  logic [SW-1:0]    s_in;
  logic [W-1:0]     s_out;
  logic             s_valid_out;
  logic             s_ready_in;
  logic [SW-1:0]    s_chan_out;

  stream_mux_n #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_in        (a_in),
    .a_valid_in  (a_valid_in),
    .a_ready_out (a_ready_out),
    .mode_in     (mode_in),
    .s_in        (s_in),
    .s_out       (s_out),
    .s_valid_out (s_valid_out),
    .s_ready_in  (s_ready_in),
    .s_chan_out  (s_chan_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          mode;
    logic [SW-1:0] sel;
    logic [CH-1:0] valid;
    logic [31:0]   data;
    logic          rdy;
    logic [CH-1:0] exp_ready;
    logic          exp_valid;
    logic [W-1:0]  exp_out;
    logic [SW-1:0] exp_chan;
  } vec_t;

  vec_t vecs[$];
  int   n_applied = 0;
  int   n_fail    = 0;

  function automatic vec_t mk(logic r, logic m, logic [SW-1:0] s, logic [CH-1:0] v,
                              logic [31:0] d, logic rd, logic [CH-1:0] er,
                              logic ev, logic [W-1:0] eo, logic [SW-1:0] ec);
    vec_t t;
    t.rst_n = r; t.mode = m; t.sel = s; t.valid = v; t.data = d; t.rdy = rd;
    t.exp_ready = er; t.exp_valid = ev; t.exp_out = eo; t.exp_chan = ec;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t t);
    rst_n      = t.rst_n;
    mode_in    = t.mode;
    s_in       = t.sel;
    a_valid_in = t.valid;
    a_in       = t.data;
    s_ready_in = t.rdy;
    #1;
    check($sformatf("v%0d.ready", idx), 32'(a_ready_out), 32'(t.exp_ready));
    @(posedge clk);
    #1;
    check($sformatf("v%0d.valid", idx), 32'(s_valid_out), 32'(t.exp_valid));
    check($sformatf("v%0d.out", idx), 32'(s_out), 32'(t.exp_out));
    check($sformatf("v%0d.chan", idx), 32'(s_chan_out), 32'(t.exp_chan));
    $display("vec %0d: rst_n=%0b mode=%0b sel=%0d valid=%b rdy=%0b -> ready=%b valid=%0b out=%02h chan=%0d",
             idx, t.rst_n, t.mode, t.sel, t.valid, t.rdy, a_ready_out, s_valid_out, s_out, s_chan_out);
  endtask

  initial begin
    int waited;
    rst_n = 1'b0; mode_in = 1'b0; s_in = '0; a_valid_in = '0; a_in = '0; s_ready_in = 1'b0;

    //               rst mode sel valid    data          rdy exp_rdy  ev out    ch
    // Reset held 2 cycles with all valids set.
    vecs.push_back(mk(0, 1, 0, 4'b1111, 32'h44332211, 1, 4'b0000, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 32'h44332211, 1, 4'b0000, 0, 8'h00, 0));
    // First round-robin grant after reset goes to channel 0.
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'h44332211, 1, 4'b0001, 1, 8'h11, 0));
    // Manual select of channel 2, three back-to-back words.
    vecs.push_back(mk(1, 0, 2, 4'b0100, 32'h00110000, 1, 4'b0100, 1, 8'h11, 2));
    vecs.push_back(mk(1, 0, 2, 4'b0100, 32'h00220000, 1, 4'b0100, 1, 8'h22, 2));
    vecs.push_back(mk(1, 0, 2, 4'b0100, 32'h00330000, 1, 4'b0100, 1, 8'h33, 2));
    // Out-of-range select: no grant, word retires, data/chan hold.
    vecs.push_back(mk(1, 0, 5, 4'b1111, 32'h99999999, 1, 4'b0000, 0, 8'h33, 2));
    // Reset again so the pointer restarts at the last channel.
    vecs.push_back(mk(0, 1, 0, 4'b1111, 32'h99999999, 1, 4'b0000, 0, 8'h00, 0));
    // Round-robin fairness, all valid: 0,1,2,3,0,1,2,3.
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'h40302010, 1, 4'b0001, 1, 8'h10, 0));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'h41312111, 1, 4'b0010, 1, 8'h21, 1));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'h42322212, 1, 4'b0100, 1, 8'h32, 2));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'h43332313, 1, 4'b1000, 1, 8'h43, 3));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'h44342414, 1, 4'b0001, 1, 8'h14, 0));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'h45352515, 1, 4'b0010, 1, 8'h25, 1));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'h46362616, 1, 4'b0100, 1, 8'h36, 2));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'h47372717, 1, 4'b1000, 1, 8'h47, 3));
    // Channels 1 and 3 dropped: 0,2,0,2.
    vecs.push_back(mk(1, 1, 0, 4'b0101, 32'h48382818, 1, 4'b0001, 1, 8'h18, 0));
    vecs.push_back(mk(1, 1, 0, 4'b0101, 32'h49392919, 1, 4'b0100, 1, 8'h39, 2));
    vecs.push_back(mk(1, 1, 0, 4'b0101, 32'h4A3A2A1A, 1, 4'b0001, 1, 8'h1A, 0));
    vecs.push_back(mk(1, 1, 0, 4'b0101, 32'h4B3B2B1B, 1, 4'b0100, 1, 8'h3B, 2));
    // Backpressure: load 0xA5 from channel 1, then stall 3 cycles.
    vecs.push_back(mk(1, 1, 0, 4'b0010, 32'h0000A500, 1, 4'b0010, 1, 8'hA5, 1));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'h5C5B5A59, 0, 4'b0000, 1, 8'hA5, 1));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'h5C5B5A59, 0, 4'b0000, 1, 8'hA5, 1));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'h5C5B5A59, 0, 4'b0000, 1, 8'hA5, 1));
    // Release: next word (channel 2) loads as 0xA5 retires.
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'h63626160, 1, 4'b0100, 1, 8'h62, 2));
    // Pointer hold: RR grant ch1, two manual words from ch3, back to RR -> ch2.
    vecs.push_back(mk(1, 1, 0, 4'b0010, 32'h00007100, 1, 4'b0010, 1, 8'h71, 1));
    vecs.push_back(mk(1, 0, 3, 4'b1111, 32'h81807F7E, 1, 4'b1000, 1, 8'h81, 3));
    vecs.push_back(mk(1, 0, 3, 4'b1111, 32'h91908F8E, 1, 4'b1000, 1, 8'h91, 3));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'hA3A2A1A0, 1, 4'b0100, 1, 8'hA2, 2));
    // Lone requester granted every cycle.
    vecs.push_back(mk(1, 1, 0, 4'b1000, 32'hB0000000, 1, 4'b1000, 1, 8'hB0, 3));
    vecs.push_back(mk(1, 1, 0, 4'b1000, 32'hC0000000, 1, 4'b1000, 1, 8'hC0, 3));
    vecs.push_back(mk(1, 1, 0, 4'b1000, 32'hD0000000, 1, 4'b1000, 1, 8'hD0, 3));
    // Mid-stream reset while stalled: held 0xD0 is discarded.
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'hE3E2E1E0, 0, 4'b0000, 1, 8'hD0, 3));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 32'hE3E2E1E0, 0, 4'b0000, 0, 8'h00, 0));
    vecs.push_back(mk(1, 1, 0, 4'b0000, 32'hE3E2E1E0, 1, 4'b0000, 0, 8'h00, 0));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 32'hF3F2F1F0, 1, 4'b0001, 1, 8'hF0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Hand sequence: manual word from channel 1 replaces a pending word,
    // then stalls with all channels valid, then drains with no new load.
    mode_in = 1'b0; s_in = 3'd1; a_valid_in = 4'b0010; a_in = 32'h00005A00; s_ready_in = 1'b1;
    #1;
    check("seq.ready_load", 32'(a_ready_out), 32'h2);
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!(s_valid_out && s_chan_out == 3'd1) && waited < 4);
    check("seq.load_timeout", 32'(waited), 32'd1);
    check("seq.load_out", 32'(s_out), 32'h5A);
    $display("seq load: waited=%0d out=%02h chan=%0d", waited, s_out, s_chan_out);
    a_valid_in = 4'b1111; a_in = 32'h01020304; s_ready_in = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("seq.stall%0d.ready", c), 32'(a_ready_out), 32'h0);
      @(posedge clk); #1;
      check($sformatf("seq.stall%0d.out", c), 32'(s_out), 32'h5A);
      check($sformatf("seq.stall%0d.chan", c), 32'(s_chan_out), 32'h1);
      $display("seq stall %0d: valid=%0b out=%02h chan=%0d", c, s_valid_out, s_out, s_chan_out);
    end
    a_valid_in = 4'b0000; s_ready_in = 1'b1;
    @(posedge clk); #1;
    check("seq.drain.valid", 32'(s_valid_out), 32'h0);
    check("seq.drain.out", 32'(s_out), 32'h5A);
    check("seq.drain.chan", 32'(s_chan_out), 32'h1);
    $display("seq drain: valid=%0b out=%02h chan=%0d", s_valid_out, s_out, s_chan_out);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

Registered N-channel multiplexer with valid/ready handshake. It selects one of CHANNELS input streams and forwards one word per cycle into a single output register. Selection is either by an explicit select input (manual mode) or by round-robin arbitration. It sits where the plain combinational muxes were used, in front of any consumer that can apply backpressure.

## Interface
- WIDTH, 8: data width per channel.
- CHANNELS, 4: number of input channels, 2..16.
- SEL_W, 2: select/channel-index width; must satisfy 2^SEL_W >= CHANNELS.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- a_in  in  CHANNELS*WIDTH  packed input data; channel i occupies bits [i*WIDTH +: WIDTH].
- a_valid_in  in  CHANNELS  per-channel valid.
- a_ready_out  out  CHANNELS  per-channel ready (combinational).
- mode_in  in  1  0 = manual select, 1 = round-robin.
- s_in  in  SEL_W  channel select, used in manual mode only.
- s_out  out  WIDTH  registered output data.
- s_valid_out  out  1  output register holds a word.
- s_ready_in  in  1  consumer accepts the output word.
- s_chan_out  out  SEL_W  index of the channel that supplied s_out.

## Operation
- Output register: fields s_out, s_chan_out, s_valid_out.
- can_load = !s_valid_out || s_ready_in.
- Grant, combinational, at most one channel:
  - Manual mode: grant = s_in when s_in < CHANNELS and a_valid_in[s_in] = 1; otherwise no grant. s_in >= CHANNELS never grants.
  - Round-robin mode: rr_ptr holds the last granted index. Search from rr_ptr+1 upward, wrapping CHANNELS-1 -> 0. The first channel with valid = 1 is granted, and rr_ptr itself is checked last.
- a_ready_out[i] = (i == grant) && can_load. All other bits are 0.
- Transfer on channel i: a_valid_in[i] && a_ready_out[i]. The register then loads the data word, s_chan_out = i, and s_valid_out = 1.
- Output handshake: the word retires when s_valid_out && s_ready_in.
  - Retire with no new load: s_valid_out goes to 0. s_out and s_chan_out hold their values.
  - Retire and load in the same cycle: the new word replaces the old. No bubble; full throughput is 1 word/cycle.
- When s_valid_out = 1 and s_ready_in = 0, s_out and s_chan_out are stable and all a_ready_out bits are 0.
- rr_ptr updates to the granted index only on a transfer in round-robin mode. Manual-mode transfers leave it unchanged.
- A mode_in or s_in change takes effect on the grant in the same cycle. A word already in the register is unaffected.
- Reset (rst_n = 0 at a clock edge, including mid-stream): s_valid_out = 0, s_out = 0, s_chan_out = 0, rr_ptr = CHANNELS-1 so channel 0 has first priority. Any held word is discarded.
- While rst_n = 0, a_ready_out is forced to all zeros.

## Timing
- Latency: 1 cycle. A word accepted at edge k appears on s_out with s_valid_out = 1 after edge k.
- a_ready_out depends combinationally on a_valid_in, mode_in, s_in and s_ready_in. s_valid_out, s_out and s_chan_out are register outputs only.
- Round-robin fairness: with all channels continuously valid and s_ready_in = 1, grants go 0,1,2,…,CHANNELS-1,0,… with one grant per cycle.
- A lone requesting channel is granted every cycle, back to back.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with all valids set -> s_valid_out = 0, s_out = 0, s_chan_out = 0, a_ready_out = 0000. After release, round-robin with all valid -> first grant to channel 0.
- Manual mode: s_in = 2, channel 2 sends 0x11,0x22,0x33, s_ready_in = 1 -> outputs 0x11,0x22,0x33 on consecutive cycles, each with s_chan_out = 2 and 1-cycle latency. Then s_in = 5 with CHANNELS = 4 -> no grant, s_valid_out drops to 0.
- Round-robin fairness: all 4 channels valid for 8 cycles with distinct data -> s_chan_out sequence 0,1,2,3,0,1,2,3. Then drop channels 1 and 3 -> sequence alternates 0,2,0,2.
- Backpressure: s_ready_in = 0 for 3 cycles while holding 0xA5 from channel 1 -> s_out stays 0xA5, s_chan_out stays 1, a_ready_out = 0000. On release, the next word loads in the same cycle 0xA5 retires.
- Pointer hold: in round-robin mode grant channel 1, switch to manual and transfer 2 words from channel 3, return to round-robin with all valid -> next grant is channel 2.
- Mid-stream reset: assert rst_n = 0 while s_valid_out = 1 and s_ready_in = 0 -> the next cycle shows s_valid_out = 0 and the held word is never delivered.
